denise_clut_pipe: RTL
=====================

DENISE_CLUT_PIPE -- requirements
Module: denise_clut_pipe

Interface
REQ-001 SHALL have parameter NCH, default 1, meaning the number of independent lookup channels (1..4).
REQ-002 SHALL have parameter AW, default 8, meaning the CLUT address width; depth is 2^AW entries, and AW shall be at least 5.
REQ-003 SHALL have parameter XOR_EN, default 1, meaning bplxor is applied to each select when 1 and ignored when 0.
REQ-004 SHALL have port clk, input, width 1: the 28MHz clock and the only clock; every flop uses its rising edge.
REQ-005 SHALL have port reset, input, width 1: a synchronous, active-high reset.
REQ-006 SHALL have port clk7_en, input, width 1: the 7MHz enable that qualifies register writes.
REQ-007 SHALL have ports reg_address_in [8:1] input, data_in [11:0] input, bank [2:0] input and loct input, width 1: the register-bus write path.
REQ-008 SHALL have ports bplxor [7:0] input and ehb_en input, width 1: display mode controls.
REQ-009 SHALL have ports sel_in [NCH*8-1:0] input and sel_vld [NCH-1:0] input: the per-channel colour selects.
REQ-010 SHALL have ports rgb_out [NCH*24-1:0] output and rgb_vld [NCH-1:0] output: the per-channel 24-bit colour.
REQ-011 SHALL have ports rb_req input, width 1, rb_ack output, width 1, and rb_data [11:0] output: the palette readback handshake.

Function
REQ-012 SHALL perform a write when reg_address_in[8:6]==3'b110 and clk7_en is high; the entry index is {bank, reg_address_in[5:1]} truncated to AW bits.
REQ-013 SHALL, when loct=0, set both the high and low nibble planes of the entry to data_in, so the low nibbles duplicate the high.
REQ-014 SHALL, when loct=1, write only the low nibble plane and leave the high plane unchanged.
REQ-015 SHALL process each channel through a 2-stage pipeline:
- Stage 1 registers the index: (sel ^ bplxor when XOR_EN) masked to bits [4:0] when ehb_en, plus the EHB flag (sel bit 5).
- Stage 2 registers the RGB.
- rgb_vld[i] equals sel_vld[i] delayed exactly 2 cycles.
REQ-016 SHALL pack the RGB as {hi[11:8],lo[11:8],hi[7:4],lo[7:4],hi[3:0],lo[3:0]}.
REQ-017 SHALL, when the EHB flag is set and ehb_en was high at stage 1, right-shift each 8-bit component by 1 with a zero MSB.
REQ-018 SHALL hold rgb_out at its last value while rgb_vld is low.
REQ-019 SHALL, when a write and a stage-1 read hit the same entry in the same cycle, return the old value; the new value is visible from the next cycle.
REQ-020 SHALL run all NCH channels concurrently with no mutual stalls.
REQ-021 SHALL implement the readback FSM with states IDLE, CAPT and ACK:
- IDLE to CAPT on rb_req high; this latches the index {bank, reg_address_in[5:1]} and loct.
- CAPT to ACK after one cycle; this registers rb_data as the high plane if latched loct=0, else the low plane.
- ACK to IDLE after one cycle, with rb_ack high only in ACK.
REQ-022 SHALL ignore rb_req while the FSM is in CAPT or ACK; rb_req held high re-triggers from IDLE on the cycle after ACK.
REQ-023 SHALL suppress writes while rb_req is high, and take the write on the first cycle rb_req is low if clk7_en is still high.

Reset
REQ-024 SHALL, on reset, clear rgb_vld, rgb_out, rb_ack and rb_data to 0, clear the pipeline valid flags, and force the FSM to IDLE.
REQ-025 SHALL abort an in-flight readback on reset, producing no rb_ack.
REQ-026 SHALL leave CLUT contents unaffected by reset.

Configuration
REQ-027 SHALL, with macro DENISE_CLUT_READBACK_EN defined, include the readback FSM of REQ-021 to REQ-023.
REQ-028 SHALL, with DENISE_CLUT_READBACK_EN undefined, remove the FSM, tie rb_ack and rb_data to 0, ignore rb_req, and never suppress writes.

Verification
REQ-029 SHALL verify the loct=0 write: write 12'hF84 to index 5, loct=0, then select 5 -> rgb_out=24'hFF8844, arriving 2 cycles after sel_vld.
REQ-030 SHALL verify the loct=1 write: after REQ-029, write 12'h123 with loct=1, then select 5 -> 24'hF1822 43, i.e. 24'hF18243.
REQ-031 SHALL verify EHB: ehb_en=1, sel=8'h25, entry 5 = 24'hFF8844 -> rgb_out=24'h7F4422.
REQ-032 SHALL verify XOR and multi-channel: NCH=2, XOR_EN=1, bplxor=8'h01, ch0 sel=4, ch1 sel=5 in the same cycle -> ch0 returns entry 5 and ch1 returns entry 4, both rgb_vld together.
REQ-033 SHALL verify write/read collision: write index 7 and stage-1 read index 7 in the same cycle -> old value returned; a read the next cycle returns the new value.
REQ-034 SHALL verify readback and reset: a 1-cycle rb_req pulse with index 5, loct=1 -> rb_ack exactly 2 cycles later with rb_data=12'h123; a repeat with reset asserted in CAPT -> no rb_ack and FSM in IDLE.

Source files
------------

// File: rtl/denise_clut_pipe.sv
// Dual-plane (hi/lo nibble) 12-bit colour lookup table with NCH independent 2-stage lookup pipes.
// Optional palette readback handshake is built when macro DENISE_CLUT_READBACK_EN is defined.
module denise_clut_pipe #(
  parameter int NCH    = 1,
  parameter int AW     = 8,
  parameter int XOR_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk7_en,
  input  logic [8:1]          reg_address_in,
  input  logic [11:0]         data_in,
  input  logic [2:0]          bank,
  input  logic                loct,
  input  logic [7:0]          bplxor,
  input  logic                ehb_en,
  input  logic [NCH*8-1:0]    sel_in,
  input  logic [NCH-1:0]      sel_vld,
  output logic [NCH*24-1:0]   rgb_out,
  output logic [NCH-1:0]      rgb_vld,
  input  logic                rb_req,
  output logic                rb_ack,
  output logic [11:0]         rb_data
);

  localparam int DEPTH = 1 << AW;

  logic [11:0] hi_mem [DEPTH];
  logic [11:0] lo_mem [DEPTH];

  logic [7:0]    reg_idx8;
  logic [AW-1:0] reg_idx;
  logic          wr_block;
  logic          wr_en;

  assign reg_idx8 = {bank, reg_address_in[5:1]};
  assign reg_idx  = AW'(reg_idx8);
  assign wr_en    = clk7_en && (reg_address_in[8:6] == 3'b110) && !wr_block;

  // No reset on the table: palette contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lo_mem[reg_idx] <= data_in;
      if (!loct) begin
        hi_mem[reg_idx] <= data_in;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [7:0]    sel_x;
      logic [AW-1:0] idx_d, idx_q;
      logic          ehb_d, ehb_q;
      logic          vld1_d, vld1_q;
      logic          vld2_d, vld2_q;
      logic [11:0]   hi_w, lo_w;
      logic [23:0]   rgb_raw;
      logic [23:0]   rgb_d, rgb_q;

      always_comb begin
        sel_x = sel_in[gi*8 +: 8];
        if (XOR_EN != 0) begin
          sel_x = sel_x ^ bplxor;
        end
        idx_d  = ehb_en ? AW'(sel_x[4:0]) : AW'(sel_x);
        ehb_d  = ehb_en & sel_x[5];
        vld1_d = sel_vld[gi];

        // Stage-1 read sees the pre-write contents on a same-cycle collision.
        hi_w    = hi_mem[idx_q];
        lo_w    = lo_mem[idx_q];
        rgb_raw = {hi_w[11:8], lo_w[11:8], hi_w[7:4], lo_w[7:4], hi_w[3:0], lo_w[3:0]};

        vld2_d = vld1_q;
        rgb_d  = rgb_q;
        if (vld1_q) begin
          if (ehb_q) begin
            rgb_d = {1'b0, rgb_raw[23:17], 1'b0, rgb_raw[15:9], 1'b0, rgb_raw[7:1]};
          end else begin
            rgb_d = rgb_raw;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          idx_q  <= '0;
          ehb_q  <= 1'b0;
          vld1_q <= 1'b0;
          vld2_q <= 1'b0;
          rgb_q  <= '0;
        end else begin
          idx_q  <= idx_d;
          ehb_q  <= ehb_d;
          vld1_q <= vld1_d;
          vld2_q <= vld2_d;
          rgb_q  <= rgb_d;
        end
      end

      assign rgb_out[gi*24 +: 24] = rgb_q;
      assign rgb_vld[gi]          = vld2_q;
    end
  endgenerate

`ifdef DENISE_CLUT_READBACK_EN
  typedef enum logic [1:0] {IDLE, CAPT, ACK} rb_state_t;

  rb_state_t     state_d, state_q;
  logic [AW-1:0] rb_idx_d, rb_idx_q;
  logic          rb_loct_d, rb_loct_q;
  logic [11:0]   rb_data_d, rb_data_q;

  always_comb begin
    state_d   = state_q;
    rb_idx_d  = rb_idx_q;
    rb_loct_d = rb_loct_q;
    rb_data_d = rb_data_q;
    case (state_q)
      IDLE: begin
        if (rb_req) begin
          state_d   = CAPT;
          rb_idx_d  = reg_idx;
          rb_loct_d = loct;
        end
      end
      CAPT: begin
        state_d   = ACK;
        rb_data_d = rb_loct_q ? lo_mem[rb_idx_q] : hi_mem[rb_idx_q];
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rb_idx_q  <= '0;
      rb_loct_q <= 1'b0;
      rb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      rb_idx_q  <= rb_idx_d;
      rb_loct_q <= rb_loct_d;
      rb_data_q <= rb_data_d;
    end
  end

  assign rb_ack   = (state_q == ACK);
  assign rb_data  = rb_data_q;
  // A pending readback owns the register bus, so writes wait until rb_req drops.
  assign wr_block = rb_req;
`else
  assign rb_ack   = 1'b0;
  assign rb_data  = 12'h000;
  assign wr_block = 1'b0;
`endif

  logic unused_sigs;
  assign unused_sigs = ^{bplxor, reg_idx8, rb_req};

endmodule
